row_scan_controller: RTL and testbench

//  Frame-level sequencer for one pixel-hierarchy level. Snapshots the active rows, then visits them one
//  at a time in ascending index order. For each row it drives row_sel_o (the external mux that presents

---
 rtl/row_scan_controller.sv | 160 ++++++++++++++++
 tb/tb_row_scan_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/row_scan_controller.sv
// Frame sequencer for one pixel-hierarchy level: snapshots active rows, walks them in ascending
// order driving the row mux and the column arbiter, and turns column grants into {row, col} events.
module row_scan_controller #(
    parameter int Lvl_ROWS    = 4,
    parameter int Lvl_ROW_ADD = 2,
    parameter int Lvl_COLS    = 2,
    parameter int Lvl_COL_ADD = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic [Lvl_ROWS-1:0]    row_req_i,
    input  logic [Lvl_COLS-1:0]    col_gnt_i,
    input  logic [Lvl_COL_ADD-1:0] col_yadd_i,
    input  logic                   col_grp_rel_i,
    output logic                   col_enable_o,
    output logic [Lvl_ROWS-1:0]    row_sel_o,
    output logic                   event_valid_o,
    output logic [Lvl_ROW_ADD-1:0] event_xadd_o,
    output logic [Lvl_COL_ADD-1:0] event_yadd_o,
    output logic                   frame_done_o,
    output logic                   timeout_err_o,
    output logic [1:0]             state_o
);

    localparam int CNT_W = $clog2(Lvl_COLS + 3);
    // Closing on this value gives exactly Lvl_COLS+2 SCAN cycles before the watchdog fires.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Lvl_COLS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        SCAN   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [Lvl_ROWS-1:0]    pending_q, pending_d;
    logic [Lvl_ROW_ADD-1:0] cur_row_q, cur_row_d;
    logic [CNT_W-1:0]       scan_cnt_q, scan_cnt_d;
    logic                   col_enable_d;
    logic [Lvl_ROWS-1:0]    row_sel_d;
    logic                   event_valid_d;
    logic [Lvl_ROW_ADD-1:0] event_xadd_d;
    logic [Lvl_COL_ADD-1:0] event_yadd_d;
    logic                   frame_done_d;
    logic                   timeout_err_d;

    logic [Lvl_ROW_ADD-1:0] low_idx;
    logic [Lvl_ROWS-1:0]    rest_rows;
    logic                   watchdog;
    logic                   row_close;

    // Handshake: event_valid_o is a one-cycle strobe with no ready; the consumer must take
    // {event_xadd_o, event_yadd_o} in the cycle it is high. Address outputs hold otherwise.

    always_comb begin
        low_idx = '0;
        for (int i = Lvl_ROWS - 1; i >= 0; i--) begin
            if (pending_q[i]) low_idx = Lvl_ROW_ADD'(i);
        end
    end

    assign rest_rows = pending_q & ~(Lvl_ROWS'(1) << cur_row_q);
    assign watchdog  = !col_grp_rel_i && (scan_cnt_q == CNT_LAST);
    assign row_close = col_grp_rel_i || watchdog;
    assign state_o   = state_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            cur_row_q     <= '0;
            scan_cnt_q    <= '0;
            col_enable_o  <= 1'b0;
            row_sel_o     <= '0;
            event_valid_o <= 1'b0;
            event_xadd_o  <= '0;
            event_yadd_o  <= '0;
            frame_done_o  <= 1'b0;
            timeout_err_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            cur_row_q     <= cur_row_d;
            scan_cnt_q    <= scan_cnt_d;
            col_enable_o  <= col_enable_d;
            row_sel_o     <= row_sel_d;
            event_valid_o <= event_valid_d;
            event_xadd_o  <= event_xadd_d;
            event_yadd_o  <= event_yadd_d;
            frame_done_o  <= frame_done_d;
            timeout_err_o <= timeout_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable_i && |row_req_i) state_d = SELECT;
            SELECT:  state_d = enable_i ? SCAN : IDLE;
            SCAN: begin
                if (!enable_i)      state_d = IDLE;
                else if (row_close) state_d = (|rest_rows) ? SELECT : DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pending_d     = pending_q;
        cur_row_d     = cur_row_q;
        scan_cnt_d    = scan_cnt_q;
        col_enable_d  = 1'b0;
        row_sel_d     = '0;
        event_valid_d = 1'b0;
        event_xadd_d  = event_xadd_o;
        event_yadd_d  = event_yadd_o;
        frame_done_d  = (state_d == DONE);
        timeout_err_d = timeout_err_o;
        case (state_q)
            IDLE: begin
                if (enable_i && |row_req_i) pending_d = row_req_i;
            end
            SELECT: begin
                if (enable_i) begin
                    row_sel_d    = Lvl_ROWS'(1) << low_idx;
                    cur_row_d    = low_idx;
                    col_enable_d = 1'b1;
                    scan_cnt_d   = '0;
                end else begin
                    pending_d = '0;
                end
            end
            SCAN: begin
                if (!enable_i) begin
                    pending_d = '0;
                end else begin
                    scan_cnt_d   = scan_cnt_q + 1'b1;
                    col_enable_d = 1'b1;
                    row_sel_d    = row_sel_o;
                    if (|col_gnt_i) begin
                        event_valid_d = 1'b1;
                        event_xadd_d  = cur_row_q;
                        event_yadd_d  = col_yadd_i;
                    end
                    if (row_close) begin
                        col_enable_d = 1'b0;
                        row_sel_d    = '0;
                        pending_d    = rest_rows;
                    end
                    if (watchdog) timeout_err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_row_scan_controller.sv
// Directed bench for row_scan_controller: a behavioural column arbiter answers the row mux,
// and expected {row, col} events are queued from each frame's configuration.
module tb_row_scan_controller;

    logic       clk;
    logic       reset_i;
    logic       enable_i;
    logic [3:0] row_req_i;
    logic [1:0] col_gnt_i;
    logic [0:0] col_yadd_i;
    logic       col_grp_rel_i;
    logic       col_enable_o;
    logic [3:0] row_sel_o;
    logic       event_valid_o;
    logic [1:0] event_xadd_o;
    logic [0:0] event_yadd_o;
    logic       frame_done_o;
    logic       timeout_err_o;
    logic [1:0] state_o;

    row_scan_controller #(
        .Lvl_ROWS(4), .Lvl_ROW_ADD(2), .Lvl_COLS(2), .Lvl_COL_ADD(1)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .row_req_i(row_req_i),
        .col_gnt_i(col_gnt_i), .col_yadd_i(col_yadd_i), .col_grp_rel_i(col_grp_rel_i),
        .col_enable_o(col_enable_o), .row_sel_o(row_sel_o), .event_valid_o(event_valid_o),
        .event_xadd_o(event_xadd_o), .event_yadd_o(event_yadd_o), .frame_done_o(frame_done_o),
        .timeout_err_o(timeout_err_o), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] exp_q[$];
    logic [1:0] cfg [4];
    logic [3:0] hold_mask;
    logic [1:0] arb_left;
    logic       arb_fresh;
    int         arb_row;
    logic       rel_prev;
    int         n_checks = 0;
    int         n_fail = 0;
    int         done_cnt, sel_cnt, en_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Behavioural column arbiter: grants the selected row's columns lowest first, one per cycle,
    // and releases with the last grant (or at once for an empty row) unless the row is held.
    task automatic arb_step();
        col_gnt_i     = '0;
        col_yadd_i    = '0;
        col_grp_rel_i = 1'b0;
        if (!col_enable_o) begin
            arb_fresh = 1'b1;
        end else begin
            if (arb_fresh) begin
                arb_row = 0;
                for (int i = 0; i < 4; i++) if (row_sel_o[i]) arb_row = i;
                arb_left  = cfg[arb_row];
                arb_fresh = 1'b0;
            end
            if (arb_left[0]) begin
                col_gnt_i = 2'b01; col_yadd_i = 1'b0; arb_left[0] = 1'b0;
            end else if (arb_left[1]) begin
                col_gnt_i = 2'b10; col_yadd_i = 1'b1; arb_left[1] = 1'b0;
            end
            if (arb_left == 2'b00 && !hold_mask[arb_row]) col_grp_rel_i = 1'b1;
        end
    endtask

    task automatic tick();
        logic [2:0] exp_ev;
        @(negedge clk);
        rel_prev = col_grp_rel_i;
        if (event_valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'(event_valid_o), 32'd0);
            end else begin
                exp_ev = exp_q.pop_front();
                check("event_xy", 32'({event_xadd_o, event_yadd_o}), 32'(exp_ev));
            end
        end
        if (frame_done_o) done_cnt++;
        if (state_o == 2'd1) sel_cnt++;
        if (col_enable_o) en_cnt++;
        arb_step();
    endtask

    task automatic expect_frame(input logic [3:0] rows);
        for (int r = 0; r < 4; r++)
            if (rows[r])
                for (int c = 0; c < 2; c++)
                    if (cfg[r][c]) exp_q.push_back({2'(r), 1'(c)});
    endtask

    task automatic run_frame(input logic [3:0] rows, input bit chk_rel);
        int n;
        bit seen;
        done_cnt = 0; sel_cnt = 0; en_cnt = 0;
        expect_frame(rows);
        row_req_i = rows;
        enable_i  = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 60) begin
            tick();
            n++;
            if (frame_done_o) begin
                seen = 1'b1;
                if (chk_rel) check("done_after_release", 32'(rel_prev), 32'd1);
            end
        end
        check("frame_done_seen", 32'(seen), 32'd1);
        row_req_i = '0;
        repeat (3) tick();
        check("done_pulse_count", 32'(done_cnt), 32'd1);
        check("events_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_col_enable"}, 32'(col_enable_o), 32'd0);
        check({tag, "_row_sel"}, 32'(row_sel_o), 32'd0);
        check({tag, "_event_valid"}, 32'(event_valid_o), 32'd0);
        check({tag, "_event_xadd"}, 32'(event_xadd_o), 32'd0);
        check({tag, "_event_yadd"}, 32'(event_yadd_o), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done_o), 32'd0);
        check({tag, "_timeout_err"}, 32'(timeout_err_o), 32'd0);
        check({tag, "_state"}, 32'(state_o), 32'd0);
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < 4; i++) cfg[i] = 2'b00;
        hold_mask = 4'b0000;
    endtask

    initial begin
        int n;
        reset_i = 1'b1; enable_i = 1'b0; row_req_i = '0;
        col_gnt_i = '0; col_yadd_i = '0; col_grp_rel_i = 1'b0;
        arb_fresh = 1'b1; arb_left = '0; arb_row = 0; rel_prev = 1'b0;
        done_cnt = 0; sel_cnt = 0; en_cnt = 0;
        clear_cfg();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset_i = 1'b0;
        repeat (2) tick();

        // Two rows, both columns each.
        clear_cfg(); cfg[0] = 2'b11; cfg[2] = 2'b11;
        run_frame(4'b0101, 1'b1);
        check("t1_select_count", 32'(sel_cnt), 32'd2);
        check("t1_scan_cycles", 32'(en_cnt), 32'd4);

        // Single top row, upper column only.
        clear_cfg(); cfg[3] = 2'b10;
        run_frame(4'b1000, 1'b1);
        check("t2_select_count", 32'(sel_cnt), 32'd1);
        check("t2_scan_cycles", 32'(en_cnt), 32'd1);

        // Empty row costs one SCAN cycle and produces nothing.
        clear_cfg(); cfg[0] = 2'b00; cfg[1] = 2'b01;
        run_frame(4'b0011, 1'b1);
        check("t3_scan_cycles", 32'(en_cnt), 32'd2);
        check("t3_no_timeout", 32'(timeout_err_o), 32'd0);

        // Row 0 never releases: watchdog closes it after Lvl_COLS+2 cycles.
        clear_cfg(); cfg[0] = 2'b11; cfg[2] = 2'b01; hold_mask = 4'b0001;
        run_frame(4'b0101, 1'b0);
        check("t4_scan_cycles", 32'(en_cnt), 32'd5);
        check("t4_timeout_set", 32'(timeout_err_o), 32'd1);
        hold_mask = 4'b0000;

        // Abort mid-SCAN of row 1, then re-run the frame.
        clear_cfg(); cfg[1] = 2'b11; cfg[2] = 2'b11;
        done_cnt = 0;
        row_req_i = 4'b0110; enable_i = 1'b1;
        n = 0;
        while (!col_enable_o && n < 20) begin tick(); n++; end
        check("t5_scan_reached", 32'(col_enable_o), 32'd1);
        exp_q.push_back(3'b010);
        tick();
        enable_i = 1'b0; row_req_i = '0;
        tick();
        check("t5_abort_col_enable", 32'(col_enable_o), 32'd0);
        check("t5_abort_row_sel", 32'(row_sel_o), 32'd0);
        check("t5_abort_state", 32'(state_o), 32'd0);
        repeat (3) tick();
        check("t5_no_frame_done", 32'(done_cnt), 32'd0);
        check("t5_events_drained", 32'(exp_q.size()), 32'd0);
        run_frame(4'b0110, 1'b1);
        check("t5_rerun_select_count", 32'(sel_cnt), 32'd2);
        check("t5_timeout_sticky", 32'(timeout_err_o), 32'd1);

        // Asynchronous reset during SCAN.
        clear_cfg(); cfg[0] = 2'b11;
        row_req_i = 4'b0001; enable_i = 1'b1;
        n = 0;
        while (!col_enable_o && n < 20) begin tick(); n++; end
        check("t6_scan_reached", 32'(col_enable_o), 32'd1);
        #2 reset_i = 1'b1;
        #1 check_all_zero("t6_async_reset");
        @(negedge clk);
        reset_i = 1'b0; enable_i = 1'b0; row_req_i = '0;
        col_gnt_i = '0; col_yadd_i = '0; col_grp_rel_i = 1'b0; arb_fresh = 1'b1;
        repeat (3) tick();
        check("t6_idle_after_reset", 32'(state_o), 32'd0);
        check("t6_events_drained", 32'(exp_q.size()), 32'd0);
        run_frame(4'b0001, 1'b1);
        check("t6_timeout_cleared", 32'(timeout_err_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
